// File: rtl/frame_aligner_pkg.sv
// Shared definitions for the serial frame aligner.
//   state_t            : aligner FSM states (HUNT, PAYLOAD, CHECK)
//   DEF_SYNC_WORD      : default 16-bit sync pattern, first received bit = bit 15
//   DEF_PAYLOAD_BYTES  : default payload bytes per frame
//   DEF_MISS_MAX       : default consecutive sync misses before lock is dropped
package frame_aligner_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [15:0] DEF_SYNC_WORD     = 16'hA5C3;
  localparam int          DEF_PAYLOAD_BYTES = 8;
  localparam int          DEF_MISS_MAX      = 3;

endpackage

// File: rtl/frame_aligner_sipo.sv
// Serial-in parallel-out byte assembler, MSB (first received bit) in bit 7.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : synchronous clear of the partial byte and bit counter
//   shift_en     : accept bit_in this cycle
//   bit_in       : serial data bit
//   last_bit     : the bit accepted this cycle (if shift_en) completes a byte
//   byte_out     : last completed byte, held until the next one
//   byte_valid   : one-cycle strobe, registered one clock after the 8th bit
module frame_aligner_sipo (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic       last_bit,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  // Only seven bits need storing: the eighth arrives on bit_in and goes
  // straight into byte_out.
  logic [6:0] shift;
  logic [2:0] bit_cnt;

  assign last_bit = (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift      <= '0;
      bit_cnt    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (clr) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift <= {shift[5:0], bit_in};
        if (last_bit) begin
          bit_cnt    <= '0;
          byte_out   <= {shift, bit_in};
          byte_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/frame_aligner.sv
// Serial frame aligner: hunts for SYNC_WORD in a 1-bit stream, then delivers
// PAYLOAD_BYTES bytes per frame and verifies the sync word at each expected
// boundary, flywheeling through up to MISS_MAX-1 consecutive misses.
// Ports:
//   clk_i        : clock, all state on rising edge
//   rst_i        : asynchronous active-high reset
//   data_i       : descrambled serial bit, one per clock
//   byte_o       : assembled payload byte, first received bit in bit 7
//   byte_valid_o : one-cycle strobe, byte_o valid
//   sof_o        : with byte_valid_o on the first payload byte of a frame
//   locked_o     : frame alignment held
//   sync_err_o   : one-cycle strobe per missed sync at an expected boundary
module frame_aligner
  import frame_aligner_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int          PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
  parameter int          MISS_MAX      = DEF_MISS_MAX
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       sof_o,
  output logic       locked_o,
  output logic       sync_err_o
);

  localparam logic [7:0] LAST_BYTE  = 8'(PAYLOAD_BYTES - 1);
  localparam logic [4:0] MISS_LIMIT = 5'(MISS_MAX);

  state_t      state, state_next;
  // Last 15 received bits; together with data_i they form the 16-bit window.
  // It shifts in every state so that a failed CHECK leaves its bits in the
  // window for the following HUNT.
  logic [14:0] window;
  logic [15:0] window_next;
  logic [7:0]  byte_cnt, byte_cnt_next;
  logic [3:0]  chk_cnt, chk_cnt_next;
  logic [3:0]  miss_cnt, miss_cnt_next;
  logic [4:0]  miss_inc;
  logic        sof_next, sync_err_next;
  logic        sipo_clr, sipo_shift, sipo_last;

  assign window_next = {window, data_i};
  assign miss_inc    = {1'b0, miss_cnt} + 5'd1;

  frame_aligner_sipo u_sipo (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (sipo_clr),
    .shift_en   (sipo_shift),
    .bit_in     (data_i),
    .last_bit   (sipo_last),
    .byte_out   (byte_o),
    .byte_valid (byte_valid_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= HUNT;
      window     <= '0;
      byte_cnt   <= '0;
      chk_cnt    <= '0;
      miss_cnt   <= '0;
      sof_o      <= 1'b0;
      sync_err_o <= 1'b0;
      locked_o   <= 1'b0;
    end else begin
      state      <= state_next;
      window     <= window_next[14:0];
      byte_cnt   <= byte_cnt_next;
      chk_cnt    <= chk_cnt_next;
      miss_cnt   <= miss_cnt_next;
      sof_o      <= sof_next;
      sync_err_o <= sync_err_next;
      locked_o   <= (state_next != HUNT);
    end
  end

  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    chk_cnt_next  = chk_cnt;
    miss_cnt_next = miss_cnt;
    sof_next      = 1'b0;
    sync_err_next = 1'b0;
    sipo_clr      = 1'b0;
    sipo_shift    = 1'b0;
    case (state)
      HUNT: begin
        // Keep the byte assembler empty so the first payload bit lands in bit 7.
        sipo_clr = 1'b1;
        if (window_next == SYNC_WORD) begin
          state_next    = PAYLOAD;
          miss_cnt_next = '0;
          byte_cnt_next = '0;
        end
      end
      PAYLOAD: begin
        sipo_shift = 1'b1;
        if (sipo_last) begin
          sof_next = (byte_cnt == 8'd0);
          if (byte_cnt == LAST_BYTE) begin
            state_next    = CHECK;
            byte_cnt_next = '0;
            chk_cnt_next  = '0;
          end else begin
            byte_cnt_next = byte_cnt + 8'd1;
          end
        end
      end
      CHECK: begin
        if (chk_cnt == 4'd15) begin
          chk_cnt_next = '0;
          if (window_next == SYNC_WORD) begin
            miss_cnt_next = '0;
            state_next    = PAYLOAD;
          end else begin
            sync_err_next = 1'b1;
            if (miss_inc < MISS_LIMIT) begin
              miss_cnt_next = miss_inc[3:0];
              state_next    = PAYLOAD;
            end else begin
              state_next = HUNT;
            end
          end
        end else begin
          chk_cnt_next = chk_cnt + 4'd1;
        end
      end
      default: state_next = HUNT;
    endcase
  end

endmodule

// File: tb/tb_frame_aligner.sv
// Testbench for frame_aligner: directed bit streams, a stream-level frame
// model checked every cycle, and literal expectations per scenario.
module tb_frame_aligner;

  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam int PB   = 8;
  localparam int MM   = 3;
  localparam int MAXN = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data = 1'b0;
  logic [7:0] byte_o;
  logic       byte_valid_o, sof_o, locked_o, sync_err_o;

  frame_aligner #(
    .SYNC_WORD    (SYNC),
    .PAYLOAD_BYTES(PB),
    .MISS_MAX     (MM)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .sof_o       (sof_o),
    .locked_o    (locked_o),
    .sync_err_o  (sync_err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit         stream [MAXN];
  bit         orig   [MAXN];
  int         nbits;
  bit         e_valid[MAXN], e_sof[MAXN], e_lock[MAXN], e_err[MAXN];
  logic [7:0] e_byte [MAXN];

  bit run_active = 1'b0;
  int cur_idx = 0;

  int         n_strobe, n_sof, n_err, n_fall;
  bit         prev_lock;
  logic [7:0] got_bytes[$];
  logic [7:0] exp_bytes[$];

  function automatic void push_bits(input logic [31:0] val, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      stream[nbits] = val[i];
      nbits++;
    end
  endfunction

  function automatic void push_frame(input logic [15:0] sw, input logic [7:0] base);
    push_bits({16'd0, sw}, 16);
    for (int i = 0; i < PB; i++) begin
      push_bits({24'd0, base + 8'(i)}, 8);
      exp_bytes.push_back(base + 8'(i));
    end
  endfunction

  // Last 16 received bits ending at index n; bits before the stream start are 0.
  function automatic logic [15:0] win_at(input int n);
    logic [15:0] w = '0;
    for (int i = n - 15; i <= n; i++) w = {w[14:0], (i >= 0) ? stream[i] : 1'b0};
    return w;
  endfunction

  // Stream-level model: find the sync, carve out frames of payload + sync,
  // and mark the output expected after each bit index.
  function automatic void build_model();
    int n, m, p, e, c, miss;
    bit found, stop;
    logic [7:0] b;
    for (int i = 0; i < MAXN; i++) begin
      e_valid[i] = 0; e_sof[i] = 0; e_lock[i] = 0; e_err[i] = 0; e_byte[i] = 8'h00;
    end
    n = 0;
    stop = 0;
    while (!stop) begin
      found = 0;
      m = n;
      while (m < nbits && !found) begin
        if (m >= 15 && win_at(m) == SYNC) found = 1;
        else m++;
      end
      if (!found) break;
      for (int j = m; j < nbits; j++) e_lock[j] = 1;
      miss = 0;
      p = m;
      while (1) begin
        for (int k = 0; k < PB; k++) begin
          e = p + 8 * (k + 1);
          if (e < nbits) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) b = {b[6:0], stream[p + 8 * k + 1 + j]};
            e_valid[e] = 1;
            e_sof[e]   = (k == 0);
            e_byte[e]  = b;
          end
        end
        c = p + 8 * PB + 16;
        if (c >= nbits) begin
          stop = 1;
          break;
        end
        if (win_at(c) == SYNC) begin
          miss = 0;
          p = c;
        end else begin
          e_err[c] = 1;
          miss++;
          if (miss == MM) begin
            for (int j = c; j < nbits; j++) e_lock[j] = 0;
            n = c + 1;
            break;
          end
          p = c;
        end
      end
    end
  endfunction

  // Single compare process: every cycle of a run, DUT outputs vs model.
  always @(posedge clk) begin
    #1;
    if (run_active) begin
      vectors++;
      if (byte_valid_o !== e_valid[cur_idx] || sof_o !== e_sof[cur_idx] ||
          locked_o !== e_lock[cur_idx] || sync_err_o !== e_err[cur_idx] ||
          (e_valid[cur_idx] && byte_o !== e_byte[cur_idx])) begin
        miscompares++;
        $display("FAIL cycle bit %0d: got v=%b sof=%b lock=%b err=%b byte=%02h, required v=%b sof=%b lock=%b err=%b byte=%02h",
                 cur_idx, byte_valid_o, sof_o, locked_o, sync_err_o, byte_o,
                 e_valid[cur_idx], e_sof[cur_idx], e_lock[cur_idx], e_err[cur_idx], e_byte[cur_idx]);
      end
      if (byte_valid_o === 1'b1) begin
        n_strobe++;
        got_bytes.push_back(byte_o);
        $display("  bit %0d: byte %02h sof=%b", cur_idx, byte_o, sof_o);
      end
      if (sof_o === 1'b1) n_sof++;
      if (sync_err_o === 1'b1) begin
        n_err++;
        $display("  bit %0d: sync error", cur_idx);
      end
      if (prev_lock && locked_o === 1'b0) n_fall++;
      prev_lock = (locked_o === 1'b1);
    end
  end

  task automatic check_int(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (byte_o !== 8'h00 || byte_valid_o !== 1'b0 || sof_o !== 1'b0 ||
        locked_o !== 1'b0 || sync_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got byte=%02h v=%b sof=%b lock=%b err=%b, required all 0",
               name, byte_o, byte_valid_o, sof_o, locked_o, sync_err_o);
    end
  endtask

  task automatic check_bytes(input string name);
    int bad = 0;
    vectors++;
    if (got_bytes.size() != exp_bytes.size()) bad = 1;
    else for (int i = 0; i < exp_bytes.size(); i++) if (got_bytes[i] !== exp_bytes[i]) bad = 1;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got %0d bytes (first %02h), required %0d bytes (first %02h)", name,
               got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx,
               exp_bytes.size(), (exp_bytes.size() > 0) ? exp_bytes[0] : 8'hxx);
    end
  endtask

  task automatic clear_run();
    nbits = 0;
    n_strobe = 0; n_sof = 0; n_err = 0; n_fall = 0;
    prev_lock = 0;
    got_bytes.delete();
    exp_bytes.delete();
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero(name);
    @(negedge clk);
    rst = 1'b0;
    clear_run();
  endtask

  task automatic run_stream();
    build_model();
    for (int n = 0; n < nbits; n++) begin
      @(negedge clk);
      data = stream[n];
      cur_idx = n;
      run_active = 1'b1;
    end
    @(negedge clk);
    run_active = 1'b0;
    data = 1'b0;
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] s_scr, s_des;
    logic        sc;
    int          bad;
    clear_run();

    // 1: sync then 01..08
    do_reset("reset s1");
    push_frame(SYNC, 8'h01);
    run_stream();
    check_bytes("s1 bytes");
    check_int("s1 sof count", n_sof, 1);
    check_int("s1 locked", int'(locked_o), 1);
    vectors++;
    if (got_bytes.size() < 8 || got_bytes[0] !== 8'h01 || got_bytes[7] !== 8'h08) begin
      miscompares++;
      $display("FAIL s1 literal bytes: got first/last %02h/%02h, required 01/08",
               (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx,
               (got_bytes.size() > 7) ? got_bytes[7] : 8'hxx);
    end

    // 2: random 5-bit prefix, two good frames
    do_reset("reset s2");
    push_bits($urandom_range(0, 31), 5);
    push_frame(SYNC, 8'h10);
    push_frame(SYNC, 8'hE0);
    run_stream();
    check_bytes("s2 bytes");
    check_int("s2 strobes", n_strobe, 16);
    check_int("s2 sync errs", n_err, 0);
    check_int("s2 sof count", n_sof, 2);

    // 3: one corrupted sync, flywheel
    do_reset("reset s3");
    push_frame(SYNC, 8'h21);
    push_frame(16'hA5C2, 8'h41);
    push_frame(SYNC, 8'h61);
    run_stream();
    check_bytes("s3 bytes");
    check_int("s3 sync errs", n_err, 1);
    check_int("s3 lock drops", n_fall, 0);
    check_int("s3 locked", int'(locked_o), 1);

    // 4: three corrupted syncs, drop lock, reacquire
    do_reset("reset s4");
    push_frame(SYNC, 8'h30);
    push_frame(16'hA5C2, 8'h50);
    push_frame(16'hA5C2, 8'h70);
    push_bits({16'd0, 16'hA5C2}, 16);
    for (int i = 0; i < PB; i++) push_bits(32'd0, 8);
    push_frame(SYNC, 8'h90);
    run_stream();
    check_bytes("s4 bytes");
    check_int("s4 strobes", n_strobe, 32);
    check_int("s4 sync errs", n_err, 3);
    check_int("s4 lock drops", n_fall, 1);
    check_int("s4 locked", int'(locked_o), 1);

    // 5: reset after 4 payload bits
    do_reset("reset s5");
    push_bits({16'd0, SYNC}, 16);
    push_bits(32'hB, 4);
    run_stream();
    check_int("s5 locked before rst", int'(locked_o), 1);
    check_int("s5 partial strobes", n_strobe, 0);
    #2 rst = 1'b1;
    #1 check_zero("s5 async reset");
    @(negedge clk);
    rst = 1'b0;
    clear_run();
    push_frame(SYNC, 8'hC1);
    run_stream();
    check_bytes("s5 reacquire bytes");
    check_int("s5 sof count", n_sof, 1);

    // 6: scrambler -> descrambler with independent seeds
    do_reset("reset s6");
    push_bits(32'd0, 20);
    push_frame(SYNC, 8'h5A);
    push_frame(SYNC, 8'h3C);
    s_scr = 12'($urandom);
    s_des = 12'($urandom);
    for (int i = 0; i < nbits; i++) begin
      orig[i] = stream[i];
      sc = stream[i] ^ s_scr[10] ^ s_scr[11];
      s_scr = {s_scr[10:0], sc};
      stream[i] = sc ^ s_des[10] ^ s_des[11];
      s_des = {s_des[10:0], sc};
    end
    bad = 0;
    for (int i = 12; i < nbits; i++) if (stream[i] != orig[i]) bad++;
    check_int("s6 descrambler settled", bad, 0);
    run_stream();
    check_bytes("s6 bytes");
    check_int("s6 sync errs", n_err, 0);
    check_int("s6 locked", int'(locked_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
